// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// Holds default bus widths, FSM state encodings and the watchdog width helper.
// Imported by the bus interface, the watchdog and the arbiter top.
package wb_arb_pkg;

  localparam int ADR_W = 30;
  localparam int DAT_W = 32;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_OWN0  = 2'd1;
  localparam arb_state_t ST_OWN1  = 2'd2;
  localparam arb_state_t ST_DRAIN = 2'd3;

  // Counter must be able to hold the value TIMEOUT itself (saturation point).
  function automatic int wd_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_master_arbiter_if.sv
// One Wishbone B4 classic port (master <-> slave signal bundle).
// master modport drives the request side, slave modport drives the termination side.
// Widths default to the SoC export port widths.
interface wb_master_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int AW = ADR_W,
  parameter int DW = DAT_W
) ();

  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic [DW/8-1:0] sel;
  logic            cyc;
  logic            stb;
  logic            we;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack;
  logic            err;

  modport master (
    output adr, dat_w, sel, cyc, stb, we, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, cyc, stb, we, cti, bte,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts cycles of strobe without termination, saturating at TIMEOUT.
// Fire is a registered one-cycle pulse the cycle after the count reaches TIMEOUT-1.
// A termination in the would-be firing cycle suppresses the pulse.
module wb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic stb,
  input  logic term,
  output logic fire
);

  localparam int CW = wd_cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT);
  localparam logic [CW-1:0] FIRE_AT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire_q, fire_d;

  // Next count: clear on idle strobe or termination, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!stb || term) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
    fire_d = stb & ~term & (cnt_q == FIRE_AT);
  end

  // Counter and fire pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      fire_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fire_q <= fire_d;
    end
  end

  assign fire = fire_q;

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone B4 classic arbiter with locked grants and a bus watchdog.
// Latency: one cycle from cyc to grant; slave signals are combinational muxes of the owner.
// Backpressure: owner holds the bus while cyc is high; the loser simply waits with cyc raised.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_master_arbiter_if.slave   m0,
  wb_master_arbiter_if.slave   m1,
  wb_master_arbiter_if.master  s,
  output logic [1:0]           grant,
  output logic                 timeout_evt
);

  arb_state_t state_q, state_d;
  // Master that held the bus most recently; the other one wins a tie.
  logic       last_owner_q, last_owner_d;
  logic       wd_fire;
  logic       own0, own1;
  logic       owner_cyc;

  assign own0 = (state_q == ST_OWN0);
  assign own1 = (state_q == ST_OWN1);

  // Slave-side mux of the owning master; watchdog fire kills cyc/stb immediately.
  always_comb begin
    s.adr   = own1 ? m1.adr   : m0.adr;
    s.dat_w = own1 ? m1.dat_w : m0.dat_w;
    s.sel   = own1 ? m1.sel   : m0.sel;
    s.we    = own1 ? m1.we    : m0.we;
    s.cti   = own1 ? m1.cti   : m0.cti;
    s.bte   = own1 ? m1.bte   : m0.bte;
    s.cyc   = ((own0 & m0.cyc) | (own1 & m1.cyc)) & ~wd_fire;
    s.stb   = ((own0 & m0.cyc & m0.stb) | (own1 & m1.cyc & m1.stb)) & ~wd_fire;
  end

  // Master-side terminations: only the owner sees them; a watchdog fire replaces the slave's.
  always_comb begin
    m0.dat_r = s.dat_r;
    m1.dat_r = s.dat_r;
    m0.ack   = own0 & s.ack & ~wd_fire;
    m1.ack   = own1 & s.ack & ~wd_fire;
    m0.err   = own0 & (wd_fire | s.err);
    m1.err   = own1 & (wd_fire | s.err);
  end

  assign owner_cyc   = last_owner_q ? m1.cyc : m0.cyc;
  assign grant       = {own1, own0};
  assign timeout_evt = wd_fire;

  // Arbitration FSM: round-robin from IDLE, locked while the owner holds cyc.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (m0.cyc && m1.cyc) state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
        else if (m0.cyc)      state_d = ST_OWN0;
        else if (m1.cyc)      state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (wd_fire) begin
          last_owner_d = 1'b0;
          state_d      = m0.cyc ? ST_DRAIN : ST_IDLE;
        end else if (!m0.cyc) begin
          last_owner_d = 1'b0;
          state_d      = m1.cyc ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (wd_fire) begin
          last_owner_d = 1'b1;
          state_d      = m1.cyc ? ST_DRAIN : ST_IDLE;
        end else if (!m1.cyc) begin
          last_owner_d = 1'b1;
          state_d      = m0.cyc ? ST_OWN0 : ST_IDLE;
        end
      end
      // last_owner already names the timed-out master; wait for it to let go.
      ST_DRAIN: begin
        if (!owner_cyc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; last_owner resets to m1 so m0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .stb   (s.stb),
    .term  (s.ack | s.err),
    .fire  (wd_fire)
  );

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for the two-master Wishbone arbiter (watchdog TIMEOUT = 16).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Every comparison is an immediate assertion against a hand-computed value.
module tb_wb_master_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       timeout_evt;

  int checks   = 0;
  int failures = 0;
  int seen;

  wb_master_arbiter_if m0_if ();
  wb_master_arbiter_if m1_if ();
  wb_master_arbiter_if s_if ();

  wb_master_arbiter #(
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .grant       (grant),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.adr = '0; m0_if.dat_w = '0; m0_if.sel = 4'hF; m0_if.cyc = 1'b0;
    m0_if.stb = 1'b0; m0_if.we = 1'b0; m0_if.cti = 3'b000; m0_if.bte = 2'b00;
    m1_if.adr = '0; m1_if.dat_w = '0; m1_if.sel = 4'hF; m1_if.cyc = 1'b0;
    m1_if.stb = 1'b0; m1_if.we = 1'b0; m1_if.cti = 3'b000; m1_if.bte = 2'b00;
    s_if.dat_r = '0; s_if.ack = 1'b0; s_if.err = 1'b0;
  endtask

  function automatic logic [7:0] all_outs();
    return {grant, timeout_evt, s_if.cyc, s_if.stb,
            m0_if.ack | m0_if.err, m1_if.ack, m1_if.err};
  endfunction

  initial begin
    reset = 1'b1;
    clear_inputs();
    // Requests and slave ack during reset must not leak through.
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; s_if.ack = 1'b1;
    step(); step();
    #1 chk("reset_outputs", all_outs(), 8'h00);
    clear_inputs();
    reset = 1'b0;

    // ---- Tie just after reset: m0 first, then hand-off to m1 ----
    step();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 30'h10;
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 30'h20;
    #1 chk("idle_no_stb", s_if.stb, 1'b0);
    step();
    #1 chk("tie_grant_m0", grant, 2'b01);
    chk("tie_adr_m0", s_if.adr, 30'h10);
    s_if.ack = 1'b1;
    #1 chk("tie_ack_m0_only", {m0_if.ack, m1_if.ack}, 2'b10);
    step();
    s_if.ack = 1'b0; m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    #1 chk("release_cycle_grant", grant, 2'b01);
    step();
    #1 chk("handoff_no_idle", grant, 2'b10);
    chk("handoff_adr_m1", s_if.adr, 30'h20);
    s_if.ack = 1'b1;
    #1 chk("handoff_ack_m1", {m0_if.ack, m1_if.ack}, 2'b01);
    step();
    s_if.ack = 1'b0; m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    step();
    #1 chk("back_to_idle", grant, 2'b00);
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    step();
    #1 chk("second_tie_m0", grant, 2'b01);
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    step();
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    step();

    // ---- Single read from m1, slave acks after 3 cycles ----
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b0; m1_if.adr = 30'h100;
    step();
    #1 chk("read_grant_m1", grant, 2'b10);
    chk("read_s_adr", s_if.adr, 30'h100);
    chk("read_no_early_ack", m1_if.ack, 1'b0);
    step(); step(); step();
    s_if.ack = 1'b1; s_if.dat_r = 32'hDEADBEEF;
    #1 chk("read_m1_ack", m1_if.ack, 1'b1);
    chk("read_m1_data", m1_if.dat_r, 32'hDEADBEEF);
    chk("read_m0_ack_low", m0_if.ack, 1'b0);
    step();
    s_if.ack = 1'b0; m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    step();

    // ---- Burst lock: 4-beat incrementing burst by m0 while m1 waits ----
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      m0_if.cti = (i == 3) ? 3'b111 : 3'b010;
      m0_if.adr = 30'h200 + 30'(i);
      s_if.ack  = 1'b1;
      #1 chk("burst_grant_ack", {grant, m0_if.ack, m1_if.ack}, 4'b0110);
      chk("burst_cti", s_if.cti, (i == 3) ? 3'b111 : 3'b010);
      step();
    end
    s_if.ack = 1'b0; m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.cti = 3'b000;
    step();
    #1 chk("burst_handoff_m1", grant, 2'b10);
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    step();

    // ---- Ack exactly at the watchdog boundary ----
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b1;
    step();
    seen = 0;
    repeat (15) begin
      step();
      seen += int'(m1_if.err | timeout_evt);
    end
    s_if.ack = 1'b1;
    #1 chk("boundary_ack", m1_if.ack, 1'b1);
    step();
    s_if.ack = 1'b0; m1_if.stb = 1'b0;
    #1 seen += int'(m1_if.err | timeout_evt);
    chk("boundary_no_err", seen, 0);
    m1_if.cyc = 1'b0;
    step();

    // ---- Watchdog: m1 writes, slave never terminates ----
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b1;
    step();
    #1 chk("wd_stb_rise", s_if.stb, 1'b1);
    seen = 0;
    repeat (15) begin
      step();
      seen += int'(m1_if.err | timeout_evt);
    end
    chk("wd_no_early_fire", seen, 0);
    step();
    #1 chk("wd_fire_err_evt", {m1_if.err, timeout_evt, m0_if.err}, 3'b110);
    chk("wd_fire_bus_off", {s_if.cyc, s_if.stb}, 2'b00);
    step();
    s_if.ack = 1'b1;
    #1 chk("drain_quiet", {m1_if.err, m1_if.ack, timeout_evt, s_if.cyc, grant}, 6'b0);
    s_if.ack = 1'b0; m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
    step();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    step();
    #1 chk("drain_exit_idle", grant, 2'b01);
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    step();

    // ---- Reset in the middle of an m0 burst (last owner before reset is m0) ----
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.cti = 3'b010;
    step();
    s_if.ack = 1'b1;
    #1 chk("rst_burst_beat1", m0_if.ack, 1'b1);
    step();
    reset = 1'b1;
    #1 chk("rst_async_outputs", all_outs(), 8'h00);
    step(); step();
    clear_inputs();
    reset = 1'b0;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    #1 chk("post_reset_idle", grant, 2'b00);
    step();
    #1 chk("post_reset_tie_m0", grant, 2'b01);
    clear_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Two-master, one-slave Wishbone B4 classic arbiter placed in front of the SoC's single exported Wishbone port.
- m0 is the EC CPU data bus; m1 is the simulation/debug bridge (the bench-driven port).
- Round-robin grant that is locked for the duration of a cycle (cyc high), including incrementing bursts.
- Bus watchdog: terminates any slave access that never acknowledges by returning err to the owning master.

Parameters:
- ADR_W, 30, word address width
- DAT_W, 32, data width; sel width is DAT_W/8
- TIMEOUT, 1024, cycles of stb-without-termination before the watchdog fires; legal range 2..65535

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- mN_adr (N=0,1)  in  ADR_W  master address
- mN_dat_w  in  DAT_W  master write data
- mN_dat_r  out  DAT_W  read data; both masters are driven from s_dat_r
- mN_sel  in  DAT_W/8  byte selects
- mN_cyc, mN_stb, mN_we  in  1 each  Wishbone control
- mN_cti  in  3  cycle type identifier
- mN_bte  in  2  burst type extension
- mN_ack, mN_err  out  1 each  cycle termination
- s_adr, s_dat_w, s_sel, s_cyc, s_stb, s_we, s_cti, s_bte  out  (widths as above)  slave side
- s_dat_r  in  DAT_W  slave read data
- s_ack, s_err  in  1 each  slave termination
- grant  out  2  one-hot current owner; 2'b00 = none
- timeout_evt  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async):
  - State is IDLE, grant = 00, last_owner = m1, so m0 wins the first tie.
  - Watchdog counter = 0, timeout_evt = 0.
  - All mN_ack, mN_err, s_cyc and s_stb are 0.
- States: IDLE, OWN0, OWN1, DRAIN.
- IDLE:
  - If exactly one mN_cyc is high, go to OWNN on the next edge.
  - If both are high, the master that is not last_owner wins.
  - Arbitration latency is one cycle. No slave signals are asserted while in IDLE.
- OWNN, slave-side outputs:
  - s_* are combinational muxes of master N's signals, selected by the registered state.
  - s_cyc = mN_cyc.
  - s_stb = mN_stb & mN_cyc.
- OWNN, master-side outputs:
  - mN_ack = s_ack and mN_err = s_err, both combinational.
  - The non-owner always sees ack = 0 and err = 0.
- OWNN, release and hand-off:
  - Stay in OWNN while mN_cyc is high, regardless of cti (bursts stay locked).
  - When mN_cyc drops: set last_owner = N.
  - If the other master's cyc is high in that same cycle, go directly to its OWN state.
  - Otherwise go to IDLE.
- Master abandons mid-access (cyc falls before termination):
  - s_cyc and s_stb fall in the same cycle.
  - A late s_ack or s_err in a later cycle is not forwarded.
- Watchdog counter:
  - Clears on s_ack, on s_err, and whenever s_stb = 0.
  - Otherwise increments by 1 per cycle while s_stb = 1, saturating at TIMEOUT.
  - Width is clog2(TIMEOUT+1).
- Watchdog fire (counter == TIMEOUT-1 with s_stb high and no s_ack/s_err):
  - On the next cycle assert mN_err = 1 for exactly one cycle and timeout_evt = 1 for one cycle.
  - Force s_cyc = s_stb = 0 and go to DRAIN.
- DRAIN:
  - s_cyc = 0; any slave termination is discarded.
  - Exit to IDLE when the former owner drops cyc, with last_owner updated.
- Simultaneous events:
  - s_ack in the same cycle the watchdog would fire: the ack wins and no err is generated.
  - s_ack and s_err together: both are forwarded unchanged (slave protocol violation; no masking).
- Reset asserted mid-transfer: all outputs return immediately to their reset values and no termination is produced.

Decomposition:
- Shared package wb_arb_pkg holds:
  - the state enum {IDLE, OWN0, OWN1, DRAIN};
  - the default widths ADR_W/DAT_W;
  - a function giving the watchdog counter width.
- One natural sub-module: wb_watchdog (counter, saturate, fire pulse). Inputs: clk, reset, stb, term. Output: fire.
- Mux and FSM stay in the top module.

Test Plan:
- Single read, m1 only, adr 0x0000_0100, slave acks with 0xDEADBEEF after 3 cycles:
  - grant = 10 one cycle after cyc rises;
  - m1_dat_r = 0xDEADBEEF coincident with m1_ack;
  - m0_ack stays 0.
- Tie: m0 and m1 raise cyc on the same edge just after reset:
  - m0 is granted first;
  - on m0 release, m1 is granted on the next edge with no IDLE cycle;
  - on the next tie, m0 wins again since last_owner = m1.
- Burst lock: m0 issues a 4-beat incrementing burst (cti 010, final beat 111) while m1 requests throughout:
  - grant stays 01 for all 4 acks;
  - m1 is granted the cycle after m0_cyc falls.
- Watchdog, TIMEOUT=16: m1 writes and the slave never acks:
  - m1_err and timeout_evt pulse exactly 16 cycles after s_stb rose;
  - s_cyc = 0 in DRAIN;
  - IDLE follows after m1 drops cyc.
- Ack at the boundary: slave acks in the cycle the counter would reach TIMEOUT:
  - m1_ack = 1, m1_err never asserts, timeout_evt = 0.
- Reset mid-burst (reset high for 2 cycles on beat 2):
  - s_cyc, all ack/err and grant = 0 asynchronously;
  - after release, the next request is arbitrated from IDLE with m0 tie priority.
